// File: rtl/if_id_buffer_if.sv
// rtl/if_id_buffer_if.sv - fetch/decode handshake bundle for the IF/ID queue
interface if_id_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush_i;
    logic              if_valid_i;
    logic [ADDR_W-1:0] if_pc_i;
    logic [INST_W-1:0] if_inst_i;
    logic              if_ready_o;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [CNT_W-1:0]  count_o;

    // Pipeline control side: drives fetch data, decode ready and redirect flush
    modport master (
        output flush_i, if_valid_i, if_pc_i, if_inst_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

    // The buffer itself
    modport slave (
        input  flush_i, if_valid_i, if_pc_i, if_inst_i, id_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );
endinterface

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - DEPTH-entry fetch-to-decode queue with flush and NOP bubbles
module if_id_buffer #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  NOP_ADDR = '0,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    if_id_buffer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] EMPTY_CNT = '0;

    // Registered state
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Next-state values
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [INST_W-1:0] inst_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_d;

    // Handshake qualifiers, all derived from registered occupancy
    logic not_full;
    logic not_empty;
    logic push;
    logic pop;

    // Occupancy flags and the accepted transfers for this cycle
    always_comb begin
        not_full  = (count_q != FULL_CNT);
        not_empty = (count_q != EMPTY_CNT);
        push      = bus.if_valid_i & not_full;
        pop       = not_empty & bus.id_ready_i;
    end

    // Storage write: only the slot under wr_ptr changes on an accepted push.
    // A flush leaves contents alone since count/pointers make them unreachable.
    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        if (push && !bus.flush_i) begin
            pc_d[wr_ptr_q]   = bus.if_pc_i;
            inst_d[wr_ptr_q] = bus.if_inst_i;
        end
    end

    // Pointer and count update; flush discards any same-cycle push/pop.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, no reset needed since empty state masks it
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    // Decode-side view: head entry when occupied, otherwise a NOP bubble
    always_comb begin
        bus.if_ready_o = not_full;
        bus.id_valid_o = not_empty;
        bus.count_o    = count_q;
        if (not_empty) begin
            bus.id_pc_o   = pc_q[rd_ptr_q];
            bus.id_inst_o = inst_q[rd_ptr_q];
        end else begin
            bus.id_pc_o   = NOP_ADDR;
            bus.id_inst_o = NOP_INST;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - directed self-checking bench for if_id_buffer
module tb_if_id_buffer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    if_id_buffer_if #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) b2 ();
    if_id_buffer_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) b4 ();

    if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv2(input logic f, input logic v, input logic [31:0] pc, input logic r);
        b2.flush_i    = f;
        b2.if_valid_i = v;
        b2.if_pc_i    = pc;
        b2.if_inst_i  = pc ^ 32'hA5000000;
        b2.id_ready_i = r;
    endtask

    task automatic state2(input string tag, input logic vld, input logic [31:0] pc,
                          input logic [1:0] cnt, input logic rdy);
        chk({tag, ".valid"}, 64'(b2.id_valid_o), 64'(vld));
        chk({tag, ".pc"},    64'(b2.id_pc_o),    64'(vld ? pc : 32'h0));
        chk({tag, ".inst"},  64'(b2.id_inst_o),  64'(vld ? (pc ^ 32'hA5000000) : NOP));
        chk({tag, ".count"}, 64'(b2.count_o),    64'(cnt));
        chk({tag, ".ready"}, 64'(b2.if_ready_o), 64'(rdy));
    endtask

    int mcount;
    int sent;
    int popped;
    logic do_push;
    logic do_pop;

    initial begin
        // Reset with fetch pushing; nothing may be captured
        rst = 1'b1;
        drv2(1'b0, 1'b1, 32'h100, 1'b0);
        b4.flush_i = 1'b0; b4.if_valid_i = 1'b0; b4.if_pc_i = '0;
        b4.if_inst_i = '0; b4.id_ready_i = 1'b0;
        tick();
        tick();
        state2("reset", 1'b0, 32'h0, 2'd0, 1'b1);
        chk("reset4.count", 64'(b4.count_o), 64'd0);
        chk("reset4.ready", 64'(b4.if_ready_o), 64'd1);
        rst = 1'b0;
        drv2(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        state2("post_reset", 1'b0, 32'h0, 2'd0, 1'b1);

        // Stream at one entry per cycle, count holds at 1
        drv2(1'b0, 1'b1, 32'h0, 1'b1); tick();
        state2("stream0", 1'b1, 32'h0, 2'd1, 1'b1);
        drv2(1'b0, 1'b1, 32'h4, 1'b1); tick();
        state2("stream4", 1'b1, 32'h4, 2'd1, 1'b1);
        drv2(1'b0, 1'b1, 32'h8, 1'b1); tick();
        state2("stream8", 1'b1, 32'h8, 2'd1, 1'b1);
        drv2(1'b0, 1'b0, 32'h0, 1'b1); tick();
        state2("stream_drain", 1'b0, 32'h0, 2'd0, 1'b1);

        // Fill while decode stalls, third push must be held off
        drv2(1'b0, 1'b1, 32'h10, 1'b0); tick();
        state2("fill1", 1'b1, 32'h10, 2'd1, 1'b1);
        drv2(1'b0, 1'b1, 32'h14, 1'b0); tick();
        state2("fill2", 1'b1, 32'h10, 2'd2, 1'b0);
        drv2(1'b0, 1'b1, 32'h18, 1'b0); tick();
        state2("full_hold", 1'b1, 32'h10, 2'd2, 1'b0);
        drv2(1'b0, 1'b1, 32'h18, 1'b1); tick();
        state2("full_pop", 1'b1, 32'h14, 2'd1, 1'b1);
        drv2(1'b0, 1'b1, 32'h18, 1'b1); tick();
        state2("push18", 1'b1, 32'h18, 2'd1, 1'b1);
        drv2(1'b0, 1'b0, 32'h0, 1'b1); tick();
        state2("fill_drain", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush a full queue while fetch and decode both handshake
        drv2(1'b0, 1'b1, 32'h20, 1'b0); tick();
        drv2(1'b0, 1'b1, 32'h24, 1'b0); tick();
        state2("pre_flush", 1'b1, 32'h20, 2'd2, 1'b0);
        drv2(1'b1, 1'b1, 32'h28, 1'b1); tick();
        state2("flush_full", 1'b0, 32'h0, 2'd0, 1'b1);
        drv2(1'b0, 1'b0, 32'h0, 1'b1); tick();
        state2("flush_after", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush with an accepted push and pop in the same cycle
        drv2(1'b0, 1'b1, 32'h30, 1'b0); tick();
        state2("pre_flush2", 1'b1, 32'h30, 2'd1, 1'b1);
        drv2(1'b1, 1'b1, 32'h34, 1'b1); tick();
        state2("flush_partial", 1'b0, 32'h0, 2'd0, 1'b1);

        // Empty pops never underflow
        for (int i = 0; i < 3; i++) begin
            drv2(1'b0, 1'b0, 32'h0, 1'b1); tick();
            state2("empty_pop", 1'b0, 32'h0, 2'd0, 1'b1);
        end

        // DEPTH=4 wrap: ten entries, decode ready on alternate cycles
        mcount = 0; sent = 0; popped = 0;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            b4.if_valid_i = (sent < 10);
            b4.if_pc_i    = 32'(sent * 4);
            b4.if_inst_i  = 32'(sent * 4) ^ 32'h5A000000;
            b4.id_ready_i = cyc[0];
            do_push = b4.if_valid_i && (mcount != 4);
            do_pop  = (mcount != 0) && b4.id_ready_i;
            if (do_pop) begin
                chk("wrap.head_pc",   64'(b4.id_pc_o),   64'(popped * 4));
                chk("wrap.head_inst", 64'(b4.id_inst_o), 64'(32'(popped * 4) ^ 32'h5A000000));
            end
            tick();
            if (do_push) sent++;
            if (do_pop)  popped++;
            if (do_push && !do_pop) mcount++;
            else if (do_pop && !do_push) mcount--;
            chk("wrap.count", 64'(b4.count_o), 64'(mcount));
            chk("wrap.ready", 64'(b4.if_ready_o), 64'(mcount != 4));
        end
        chk("wrap.popped", 64'(popped), 64'd10);
        b4.if_valid_i = 1'b0;
        b4.id_ready_i = 1'b1;
        tick();
        chk("wrap.end_valid", 64'(b4.id_valid_o), 64'd0);
        chk("wrap.end_inst",  64'(b4.id_inst_o),  64'(NOP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Parametrised fetch-to-decode pipeline buffer; replaces the single-entry IF/ID latch.
- A DEPTH-entry circular queue of {pc, inst} pairs with valid/ready handshakes on both sides, plus a flush input.
- Fetch keeps issuing while decode stalls.
- On flush or reset, and whenever the queue is empty, decode sees a NOP bubble.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.
- DEPTH, 2, number of queue entries; power of two, at least 2.
- NOP_ADDR, 0, pc value presented to decode when no valid entry.
- NOP_INST, 32'h00000013, instruction presented to decode when no valid entry (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush_i  input  1  discard all queued entries (branch/jump/trap redirect).
- if_valid_i  input  1  fetch presents a valid pc/inst this cycle.
- if_pc_i  input  ADDR_W  fetched instruction address.
- if_inst_i  input  INST_W  fetched instruction.
- if_ready_o  output  1  buffer accepts a push this cycle.
- id_valid_o  output  1  head entry valid for decode.
- id_ready_i  input  1  decode consumes head entry this cycle.
- id_pc_o  output  ADDR_W  head pc, or NOP_ADDR when empty.
- id_inst_o  output  INST_W  head inst, or NOP_INST when empty.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- State: storage arrays pc_q[DEPTH] and inst_q[DEPTH], wr_ptr and rd_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and count (0..DEPTH).
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- if_ready_o = (count != DEPTH).
- id_valid_o = (count != 0).
- id_pc_o/id_inst_o = pc_q[rd_ptr]/inst_q[rd_ptr] when count != 0, else NOP_ADDR/NOP_INST.
- push = if_valid_i & if_ready_o. pop = id_valid_o & id_ready_i.
- Priority on each rising edge:
  - rst: wr_ptr = rd_ptr = count = 0. Storage contents are don't-care.
  - else flush_i: same as rst. Any push or pop in that cycle is discarded.
  - else:
    - push: write entry[wr_ptr], wr_ptr+1.
    - pop: rd_ptr+1.
    - count: +1 on push only, -1 on pop only, unchanged on both.
- Reset values (cycle after rst sampled high):
  - id_valid_o=0, id_pc_o=NOP_ADDR, id_inst_o=NOP_INST.
  - if_ready_o=1, count_o=0.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle), provided all earlier entries have been popped.
- Throughput: one push and one pop per cycle sustained. A push and pop in the same cycle at count in 1..DEPTH-1 leaves count unchanged.
- Full: if_ready_o=0. if_valid_i is ignored and the fetch side must hold its data. A pop while full frees a slot for the next cycle, not the same cycle.
- Empty: id_valid_o=0, and id_ready_i is ignored (no underflow). A push while empty is not bypassed; it appears the next cycle.
- Pointer wrap: wr_ptr and rd_ptr roll from DEPTH-1 to 0. Ordering is strictly FIFO.
- Flush or reset mid-stream: all entries are lost regardless of handshake state. The next cycle presents a NOP bubble.

Test Plan:
- Reset: hold rst=1 for 2 cycles with if_valid_i=1 and pc=0x100 -> id_valid_o=0, id_inst_o=0x00000013, id_pc_o=0, count_o=0, if_ready_o=1.
- Stream: DEPTH=2, id_ready_i=1, push pc 0x0,0x4,0x8 on consecutive cycles -> id_pc_o=0x0,0x4,0x8 each one cycle after its push, count_o stays 1, no bubbles.
- Fill/stall: id_ready_i=0, push 0x10 and 0x14 -> count_o=2, if_ready_o=0. Third push 0x18 is not accepted. Raise id_ready_i -> outputs 0x10 then 0x14; 0x18 is accepted once if_ready_o=1 and appears after 0x14.
- Flush: queue holds 0x20,0x24; assert flush_i together with push 0x28 and pop -> next cycle count_o=0, id_inst_o=NOP_INST, and 0x28 is never output.
- Wrap: DEPTH=4, push and pop 10 entries 0x0..0x24 with alternating id_ready_i -> exact order 0x0..0x24, pointers wrap twice, count_o never exceeds 4.
- Empty pop: count_o=0 with id_ready_i=1 for 3 cycles -> count_o stays 0 and outputs stay NOP.
